// File: rtl/color_point_extractor.sv
// color_point_extractor
// Front end of the marker-tracking path. Tracks raster coordinates of the
// incoming YCrCb stream, classifies each pixel into one of four colour
// windows, qualifies runs of same-class pixels along a line and emits one
// (color, x, y) point per qualifying pixel. frame_flag is vsync delayed by
// one clock so the downstream stage can accumulate during active video and
// compute during blanking.
//
// Pipeline: edge t captures the pixel class and coordinates (p1), edge t+1
// updates the run length and decides qualification (p2), edge t+2 drives
// the output registers.

module color_point_extractor #(
  parameter int          WIDTH  = 640,
  parameter int          HEIGHT = 480,
  parameter logic [7:0]  Y_MIN  = 8'd40,
  // Byte k of each packed word holds the inclusive bound of class k.
  parameter logic [31:0] CR_MIN = 32'h008C_64C8,
  parameter logic [31:0] CR_MAX = 32'h3CC8_A0FF,
  parameter logic [31:0] CB_MIN = 32'hC88C_6400,
  parameter logic [31:0] CB_MAX = 32'hFFC8_A03C,
  parameter int          RUN    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       pixel_valid,
  input  logic [7:0] y,
  input  logic [7:0] cr,
  input  logic [7:0] cb,
  output logic [1:0] color,
  output logic [9:0] interesting_x,
  output logic [8:0] interesting_y,
  output logic       interesting_flag,
  output logic       frame_flag
);

  localparam logic [9:0] X_LAST  = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST  = 9'(HEIGHT - 1);
  localparam logic [3:0] RUN_THR = 4'(RUN);
  localparam logic [3:0] RUN_SAT = 4'd15;

  // Returns {hit, class}. Scanning from class 3 down to 0 lets the lowest
  // matching class overwrite any higher one, so overlaps resolve to lowest k.
  function automatic logic [2:0] classify(input logic [7:0] luma,
                                          input logic [7:0] cr_v,
                                          input logic [7:0] cb_v);
    logic [2:0] res;
    res = 3'b000;
    if (luma >= Y_MIN) begin
      for (int k = 3; k >= 0; k--) begin
        if ((cr_v >= CR_MIN[8*k +: 8]) && (cr_v <= CR_MAX[8*k +: 8]) &&
            (cb_v >= CB_MIN[8*k +: 8]) && (cb_v <= CB_MAX[8*k +: 8])) begin
          res = {1'b1, 2'(k)};
        end
      end
    end
    return res;
  endfunction

  // Run-length increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] run_sat_inc(input logic [3:0] r);
    return (r == RUN_SAT) ? RUN_SAT : r + 4'd1;
  endfunction

  logic       accept;
  logic [2:0] class_now;

  logic [9:0] x_cnt_q, x_cnt_d;
  logic [8:0] y_cnt_q, y_cnt_d;
  logic       frame_q, frame_d;

  logic       vld_p1_q, vld_p1_d;
  logic       hit_p1_q, hit_p1_d;
  logic [1:0] cls_p1_q, cls_p1_d;
  logic [9:0] x_p1_q, x_p1_d;
  logic [8:0] y_p1_q, y_p1_d;

  logic [3:0] run_q, run_d;
  logic       last_hit_q, last_hit_d;
  logic [1:0] last_cls_q, last_cls_d;
  logic       vld_p2_q, vld_p2_d;
  logic [1:0] cls_p2_q, cls_p2_d;
  logic [9:0] x_p2_q, x_p2_d;
  logic [8:0] y_p2_q, y_p2_d;

  logic       flag_q, flag_d;
  logic [1:0] color_q, color_d;
  logic [9:0] out_x_q, out_x_d;
  logic [8:0] out_y_q, out_y_d;

  assign accept    = pixel_valid & ~vsync;
  assign class_now = classify(y, cr, cb);

  // Raster coordinate counters; vertical blank pins them to the origin.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    frame_d = vsync;
    if (vsync) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (pixel_valid) begin
      if (x_cnt_q == X_LAST) begin
        x_cnt_d = '0;
        y_cnt_d = (y_cnt_q == Y_LAST) ? 9'd0 : y_cnt_q + 9'd1;
      end else begin
        x_cnt_d = x_cnt_q + 10'd1;
      end
    end
  end

  // ---- stage p1: class and coordinates of the accepted pixel ----
  always_comb begin
    vld_p1_d = accept;
    hit_p1_d = class_now[2];
    cls_p1_d = class_now[1:0];
    x_p1_d   = x_cnt_q;
    y_p1_d   = y_cnt_q;
  end

  // ---- stage p2: run-length update and qualification ----
  always_comb begin
    run_d      = run_q;
    last_hit_d = last_hit_q;
    last_cls_d = last_cls_q;
    vld_p2_d   = 1'b0;
    cls_p2_d   = cls_p2_q;
    x_p2_d     = x_p2_q;
    y_p2_d     = y_p2_q;
    if (vld_p1_q) begin
      last_hit_d = hit_p1_q;
      last_cls_d = cls_p1_q;
      if (!hit_p1_q) begin
        run_d = 4'd0;
      end else if (x_p1_q == 10'd0) begin
        run_d = 4'd1;
      end else if (last_hit_q && (last_cls_q == cls_p1_q)) begin
        run_d = run_sat_inc(run_q);
      end else begin
        run_d = 4'd1;
      end
      if (hit_p1_q && (run_d >= RUN_THR)) begin
        vld_p2_d = 1'b1;
        cls_p2_d = cls_p1_q;
        x_p2_d   = x_p1_q;
        y_p2_d   = y_p1_q;
      end
    end
  end

  // ---- output stage: strobe for one cycle, hold the point between strobes ----
  always_comb begin
    flag_d  = vld_p2_q;
    color_d = color_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    if (vld_p2_q) begin
      color_d = cls_p2_q;
      out_x_d = x_p2_q;
      out_y_d = y_p2_q;
    end
  end

  // Counter and frame-flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      frame_q <= 1'b0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      frame_q <= frame_d;
    end
  end

  // Stage p1 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      hit_p1_q <= 1'b0;
      cls_p1_q <= '0;
      x_p1_q   <= '0;
      y_p1_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      hit_p1_q <= hit_p1_d;
      cls_p1_q <= cls_p1_d;
      x_p1_q   <= x_p1_d;
      y_p1_q   <= y_p1_d;
    end
  end

  // Stage p2 registers, including the run-length state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= '0;
      last_hit_q <= 1'b0;
      last_cls_q <= '0;
      vld_p2_q   <= 1'b0;
      cls_p2_q   <= '0;
      x_p2_q     <= '0;
      y_p2_q     <= '0;
    end else begin
      run_q      <= run_d;
      last_hit_q <= last_hit_d;
      last_cls_q <= last_cls_d;
      vld_p2_q   <= vld_p2_d;
      cls_p2_q   <= cls_p2_d;
      x_p2_q     <= x_p2_d;
      y_p2_q     <= y_p2_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q  <= 1'b0;
      color_q <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      flag_q  <= flag_d;
      color_q <= color_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
    end
  end

  assign interesting_flag = flag_q;
  assign color            = color_q;
  assign interesting_x    = out_x_q;
  assign interesting_y    = out_y_q;
  assign frame_flag       = frame_q;

endmodule

// File: tb/tb_color_point_extractor.sv
// Bench for color_point_extractor: directed scenarios plus randomized pixel
// streams, compared cycle by cycle against a behavioural point model.
// HEIGHT is reduced to 8 lines so a whole frame fits a short run.

module tb_color_point_extractor;

  localparam int W     = 640;
  localparam int H     = 8;
  localparam int RUN_N = 3;
  localparam int YMIN  = 40;

  // Colour windows: index = class.
  int cr_lo[4] = '{200, 100, 140, 0};
  int cr_hi[4] = '{255, 160, 200, 60};
  int cb_lo[4] = '{0, 100, 140, 200};
  int cb_hi[4] = '{60, 160, 200, 255};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [7:0] y = '0;
  logic [7:0] cr = '0;
  logic [7:0] cb = '0;
  logic [1:0] color;
  logic [9:0] interesting_x;
  logic [8:0] interesting_y;
  logic       interesting_flag;
  logic       frame_flag;

  color_point_extractor #(
    .WIDTH (W),
    .HEIGHT(H),
    .Y_MIN (8'd40),
    .CR_MIN(32'h008C_64C8),
    .CR_MAX(32'h3CC8_A0FF),
    .CB_MIN(32'hC88C_6400),
    .CB_MAX(32'hFFC8_A03C),
    .RUN   (RUN_N)
  ) dut (
    .clk             (clk),
    .reset           (rst),
    .vsync           (vsync),
    .pixel_valid     (pixel_valid),
    .y               (y),
    .cr              (cr),
    .cb              (cb),
    .color           (color),
    .interesting_x   (interesting_x),
    .interesting_y   (interesting_y),
    .interesting_flag(interesting_flag),
    .frame_flag      (frame_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model state.
  typedef struct {
    int due;
    int c;
    int x;
    int y;
  } pt_t;
  pt_t q[$];
  int mx = 0, my = 0, mrun = 0, mlast = -1;
  int hc = 0, hx = 0, hy = 0;
  bit vs_drv = 1'b0;
  int kind = 5;

  function automatic int ref_class(int yy, int rr, int bb);
    if (yy < YMIN) return -1;
    for (int k = 0; k < 4; k++)
      if (rr >= cr_lo[k] && rr <= cr_hi[k] && bb >= cb_lo[k] && bb <= cb_hi[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    mx = 0; my = 0; mrun = 0; mlast = -1;
    hc = 0; hx = 0; hy = 0;
  endtask

  task automatic model_step(bit vs, bit pv, int yy, int rr, int bb);
    int c;
    if (vs) begin
      mx = 0;
      my = 0;
    end else if (pv) begin
      c = ref_class(yy, rr, bb);
      if (c < 0)            mrun = 0;
      else if (mx == 0)     mrun = 1;
      else if (c == mlast)  mrun = (mrun < 15) ? mrun + 1 : 15;
      else                  mrun = 1;
      mlast = c;
      if (c >= 0 && mrun >= RUN_N) q.push_back('{cyc + 3, c, mx, my});
      mx++;
      if (mx == W) begin
        mx = 0;
        my = (my + 1) % H;
      end
    end
  endtask

  task automatic pix(bit vs, bit pv, int yy, int rr, int bb);
    @(negedge clk);
    vsync = vs;
    pixel_valid = pv;
    y  = 8'(yy);
    cr = 8'(rr);
    cb = 8'(bb);
    vs_drv = vs;
    if (!rst) model_step(vs, pv, yy, rr, bb);
  endtask

  task automatic rand_pix(bit pv_rand);
    int rr, bb, yy;
    bit pv;
    if ($urandom_range(0, 9) < 3) kind = int'($urandom_range(0, 5));
    case (kind)
      0: begin rr = int'($urandom_range(200, 255)); bb = int'($urandom_range(0, 60)); end
      1: begin rr = int'($urandom_range(100, 160)); bb = int'($urandom_range(100, 160)); end
      2: begin rr = int'($urandom_range(140, 200)); bb = int'($urandom_range(140, 200)); end
      3: begin rr = int'($urandom_range(0, 60));    bb = int'($urandom_range(200, 255)); end
      4: begin rr = int'($urandom_range(138, 162)); bb = int'($urandom_range(138, 162)); end
      default: begin rr = int'($urandom_range(0, 255)); bb = int'($urandom_range(0, 255)); end
    endcase
    yy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 45)) : int'($urandom_range(40, 255));
    pv = pv_rand ? ($urandom_range(0, 9) != 0) : 1'b1;
    pix(1'b0, pv, yy, rr, bb);
  endtask

  task automatic feed_to(int tx, int ty);
    int guard = 0;
    while (!(mx == tx && my == ty) && guard < 20000) begin
      rand_pix(1'b1);
      guard++;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  int ef;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      ef = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ef = 1;
        hc = q[0].c;
        hx = q[0].x;
        hy = q[0].y;
        void'(q.pop_front());
      end
      chk("interesting_flag", int'(interesting_flag), ef);
      chk("color", int'(color), hc);
      chk("interesting_x", int'(interesting_x), hx);
      chk("interesting_y", int'(interesting_y), hy);
      chk("frame_flag", int'(frame_flag), int'(vs_drv));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flag", int'(interesting_flag), 0);
    chk("rst_color", int'(color), 0);
    chk("rst_x", int'(interesting_x), 0);
    chk("rst_y", int'(interesting_y), 0);
    chk("rst_frame", int'(frame_flag), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // vsync 1 -> 0, then 10 class-0 pixels from x=0 on line 0.
    pix(1'b1, 1'b0, 0, 0, 0);
    pix(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 10; i++) pix(1'b0, 1'b1, 100, 220, 30);

    // Line 1: class 2 run, overlap pixel at x=5 credits class 1, then Y_MIN edge.
    feed_to(0, 1);
    for (int i = 0; i < 5; i++) pix(1'b0, 1'b1, 100, 180, 180);
    pix(1'b0, 1'b1, 100, 150, 150);
    pix(1'b0, 1'b1, 100, 120, 120);
    pix(1'b0, 1'b1, 100, 120, 120);
    for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, 40, 220, 30);
    pix(1'b0, 1'b1, 39, 220, 30);
    pix(1'b0, 1'b1, 40, 220, 30);

    // Run broken at the line boundary between lines 4 and 5.
    feed_to(637, 4);
    pix(1'b0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 5; i++) pix(1'b0, 1'b1, 100, 30, 230);

    // pixel_valid gaps inside a run at the start of line 6.
    feed_to(0, 6);
    pix(1'b0, 1'b1, 100, 220, 30);
    pix(1'b0, 1'b0, 100, 220, 30);
    pix(1'b0, 1'b1, 100, 220, 30);
    pix(1'b0, 1'b0, 100, 220, 30);
    pix(1'b0, 1'b1, 100, 220, 30);
    pix(1'b0, 1'b1, 100, 220, 30);

    // Finish the frame; coordinates wrap to line 0, then vertical blank.
    feed_to(0, 0);
    for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, 100, 220, 30);
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 100, 220, 30);
    for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, 100, 220, 30);

    // Randomized stream with occasional vertical blanks.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int j = 0; j < int'($urandom_range(3, 6)); j++)
          pix(1'b1, 1'($urandom_range(0, 1)), 100, 220, 30);
      end else begin
        rand_pix(1'b1);
      end
    end

    // Asynchronous reset one cycle after a qualifying pixel is accepted.
    for (int i = 0; i < 4; i++) pix(1'b0, 1'b1, 100, 220, 30);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_flag", int'(interesting_flag), 0);
    chk("arst_color", int'(color), 0);
    chk("arst_x", int'(interesting_x), 0);
    chk("arst_y", int'(interesting_y), 0);
    chk("arst_frame", int'(frame_flag), 0);
    pix(1'b0, 1'b0, 0, 0, 0);
    pix(1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pix(1'b0, 1'b1, 100, 220, 30);
    for (int i = 0; i < 4; i++) pix(1'b0, 1'b0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/color_point_extractor.md
Name: color_point_extractor

Overview:
- Front end of the marker-tracking path, directly upstream of the object recognition stage.
- Takes the raster YCrCb pixel stream from the video decoder and tracks the pixel x/y coordinates.
- Classifies each pixel into one of four marker colours and emits one (color, x, y) point per qualifying pixel.
- Drives frame_flag from vertical blank so the downstream stage can accumulate over active video and compute during blanking.

Parameters:
- WIDTH, 640: active pixels per line.
- HEIGHT, 480: active lines per frame.
- Y_MIN, 8'd40: minimum luma for any class; darker pixels never classify.
- CR_MIN, 32'h..., packed 4x8: byte k is the inclusive lower Cr bound of class k.
- CR_MAX, 32'h..., packed 4x8: byte k is the inclusive upper Cr bound of class k.
- CB_MIN, 32'h..., packed 4x8: byte k is the inclusive lower Cb bound of class k.
- CB_MAX, 32'h..., packed 4x8: byte k is the inclusive upper Cb bound of class k.
- RUN, 3: consecutive same-class pixels required on a line before points are emitted; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- vsync  in  1  high during vertical blank
- pixel_valid  in  1  a pixel is present on y/cr/cb this cycle
- y  in  8  luma
- cr  in  8  red chroma
- cb  in  8  blue chroma
- color  out  2  class of the emitted point
- interesting_x  out  10  column of the emitted point
- interesting_y  out  9  line of the emitted point
- interesting_flag  out  1  one-cycle strobe: color/x/y valid
- frame_flag  out  1  registered vsync (level)

Behaviour:
- Reset values: color=0, interesting_x=0, interesting_y=0, interesting_flag=0, frame_flag=0. Internally x_cnt=0, y_cnt=0, run=0, last_class=none, and all pipeline valid bits are 0.
- Coordinate counters advance only on accepted pixels (pixel_valid=1 and vsync=0).
  - x_cnt increments per accepted pixel. At WIDTH-1 it wraps to 0 and y_cnt increments.
  - y_cnt wraps from HEIGHT-1 to 0.
  - Any cycle with vsync=1 forces x_cnt=0 and y_cnt=0.
  - Pixels presented while vsync=1 are discarded.
- Stage 1 (registered): compute the class of the accepted pixel.
  - A pixel matches class k iff y>=Y_MIN and CR_MIN[k]<=cr<=CR_MAX[k] and CB_MIN[k]<=cb<=CB_MAX[k].
  - If several classes match, the lowest k wins. If none match, the result is "none".
  - Register the class, x_cnt, y_cnt and a valid bit.
- Stage 2 (registered): run-length qualification.
  - On a valid stage-1 pixel whose class equals last_class (and is not "none"), run increments, saturating at 15.
  - On a valid stage-1 pixel with a different class, run=1 and last_class takes the new class.
  - A pixel with x=0 starts a new line: run=1 for its class, or run=0 if its class is "none".
  - A "none" pixel sets run=0.
  - interesting_flag=1 for one cycle when the updated run>=RUN. color, interesting_x and interesting_y then carry that pixel's class and coordinates.
- Latency: a pixel accepted on clock edge t produces its outputs on edge t+2. Gaps in pixel_valid do not alter run, but they do insert bubbles: interesting_flag stays 0 for bubble cycles.
- Between strobes, color/x/y hold their last values.
- Downstream uses frame_flag as a level: frame_flag = vsync delayed by 1 cycle.
  - A point from a pixel accepted in the 2 cycles before vsync rises still emits; it may coincide with frame_flag=1.
  - Apart from those in-flight points, interesting_flag is never asserted while frame_flag=1.
- Reset asserted mid-line or mid-frame clears the pipeline immediately; no pending strobe survives.
- After reset is released, counting restarts at (0,0) on the first accepted pixel. Frame alignment is regained at the next vsync.

Test Plan:
- Reset with RUN=3, class-0 window Cr 200..255 / Cb 0..60. Drive vsync 1→0, then feed 10 pixels (y=100, cr=220, cb=30) from x=0 on line 0. Required: no strobe for x=0,1; strobes with color=0 and x=2..9, y=0, each exactly 2 cycles after its pixel.
- Pixel matching both class 1 and class 2 windows at x=5 → class 1 is the only class credited.
- Run broken at the line boundary: class-3 pixels at x=638,639 of line 4, then x=0,1 of line 5 → no strobes for those 4 pixels (RUN=3). Line-5 point y values equal 5.
- pixel_valid toggled 1,0,1,0,1 over 3 matching pixels at x=0..2 → one strobe for x=2; exactly 3 accepted pixels; x_cnt=3 afterwards.
- Full 640x480 frame, then vsync=1: y_cnt wraps to 0. frame_flag rises 1 cycle after vsync. Pixels driven during vsync produce no strobe and no counter change.
- Assert reset asynchronously (between clock edges) one cycle after a qualifying pixel is accepted. Required: interesting_flag=0 and all outputs 0 immediately, with no strobe at t+2. First post-reset pixel is at x=0, y=0.
